rip_memory_responder: RTL

- Responder side of the core's word-addressed data port (port 1) and instruction-fetch port (port 2).
- Serves RAM-region accesses from a local byte-enable dual-port RAM with fixed 1-cycle read latency.
- Serves MMIO-region accesses through a req/ack bus, controlled by a small FSM.
- Raises a registered busy so the core drops ma_ready until the MMIO access completes.

---
 rtl/rip_memory_responder_pkg.sv | 13 +
 rtl/rip_memory_responder_if.sv | 29 ++
 rtl/rip_memory_responder_bram_tdp.sv | 52 +++++
 rtl/rip_memory_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rip_memory_responder_pkg.sv
// Shared constants and types for the RIP memory responder.
// RIP_MMIO_TIMEOUT_EN selects the MMIO timeout read value defined here.
package rip_memory_responder_pkg;

  localparam logic [31:0] MMIO_BASE_WORD_DEFAULT = 32'h0800_0000;
  localparam logic [31:0] MMIO_TIMEOUT_RDATA     = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mmio_state_e;

endpackage

// File: rtl/rip_memory_responder_if.sv
// MMIO req/ack bus between the memory responder (master) and an MMIO device (slave).
interface rip_memory_responder_if;

  logic        mmio_req;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_ack;
  logic [31:0] mmio_rdata;

  modport master (
    output mmio_req,
    output mmio_we,
    output mmio_addr,
    output mmio_wdata,
    input  mmio_ack,
    input  mmio_rdata
  );

  modport slave (
    input  mmio_req,
    input  mmio_we,
    input  mmio_addr,
    input  mmio_wdata,
    output mmio_ack,
    output mmio_rdata
  );

endinterface

// File: rtl/rip_memory_responder_bram_tdp.sv
// Dual-port RAM: byte-enable write/read port A, read-only port B.
// Read-first, 1-cycle read latency; output registers hold when not enabled.
module rip_bram_tdp #(
  parameter int unsigned AW = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    we_a_i,
  input  logic          re_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [31:0]   din_a_i,
  output logic [31:0]   dout_a_o,
  input  logic          re_b_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [31:0]   dout_b_o
);

  localparam int unsigned Depth = 1 << AW;

  logic [31:0] mem [Depth];
  logic [31:0] dout_a_q;
  logic [31:0] dout_b_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_a_i[i]) begin
        mem[addr_a_i][8*i +: 8] <= din_a_i[8*i +: 8];
      end
    end
  end

  // Non-blocking reads of mem see the pre-write contents: read-first on both ports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_a_q <= '0;
    end else if (re_a_i) begin
      dout_a_q <= mem[addr_a_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_b_q <= '0;
    end else if (re_b_i) begin
      dout_b_q <= mem[addr_b_i];
    end
  end

  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;

endmodule

// File: rtl/rip_memory_responder.sv
// Data/fetch port responder: RAM region from local BRAM, MMIO region via req/ack FSM.
// Optional RIP_MMIO_TIMEOUT_EN aborts an unacknowledged MMIO access after MMIO_TIMEOUT cycles.
module rip_memory_responder
  import rip_memory_responder_pkg::*;
#(
  parameter int unsigned RAM_AW         = 14,
  parameter logic [31:0] MMIO_BASE_WORD = MMIO_BASE_WORD_DEFAULT,
  parameter int unsigned MMIO_TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    we_1,
  input  logic                          re_1,
  input  logic [31:0]                   addr_1,
  input  logic [31:0]                   din_1,
  output logic [31:0]                   dout_1,
  input  logic                          re_2,
  input  logic [31:0]                   addr_2,
  output logic [31:0]                   dout_2,
  output logic                          busy,
  rip_memory_responder_if.master        mmio
);

  if (MMIO_TIMEOUT == 0) begin : g_bad_timeout
    $error("MMIO_TIMEOUT must be nonzero");
  end

  mmio_state_e state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  mmio_we_q, mmio_we_d;
  logic [31:0] mmio_addr_q, mmio_addr_d;
  logic [31:0] mmio_wdata_q, mmio_wdata_d;
  logic [31:0] mmio_dout_q, mmio_dout_d;
  logic        dout1_mmio_q, dout1_mmio_d;
`ifdef RIP_MMIO_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic        is_mmio;
  logic        ram_access;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_dout_a;
  logic        unused_addr_2;

  assign is_mmio    = (addr_1 >= MMIO_BASE_WORD);
  assign ram_access = (state_q == StIdle) && !is_mmio;
  assign ram_we     = ram_access ? we_1 : 4'b0000;
  assign ram_re     = ram_access && re_1;

  // Fetch port aliases into RAM by low index bits only.
  assign unused_addr_2 = ^addr_2[31:RAM_AW];

  rip_bram_tdp #(
    .AW(RAM_AW)
  ) u_bram (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_a_i   (ram_we),
    .re_a_i   (ram_re),
    .addr_a_i (addr_1[RAM_AW-1:0]),
    .din_a_i  (din_1),
    .dout_a_o (ram_dout_a),
    .re_b_i   (re_2),
    .addr_b_i (addr_2[RAM_AW-1:0]),
    .dout_b_o (dout_2)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    mmio_we_d    = mmio_we_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    mmio_dout_d  = mmio_dout_q;
    dout1_mmio_d = dout1_mmio_q;
`ifdef RIP_MMIO_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ram_re) begin
          dout1_mmio_d = 1'b0;
        end
        if (is_mmio && (re_1 || (|we_1))) begin
          mmio_we_d    = we_1;
          mmio_addr_d  = addr_1;
          mmio_wdata_d = din_1;
          busy_d       = 1'b1;
          state_d      = StWait;
`ifdef RIP_MMIO_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      StWait: begin
        // An ack arriving on the timeout cycle takes priority.
        if (mmio.mmio_ack) begin
          if (mmio_we_q == 4'b0000) begin
            mmio_dout_d  = mmio.mmio_rdata;
            dout1_mmio_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = StIdle;
`ifdef RIP_MMIO_TIMEOUT_EN
        end else if (tmo_cnt_q == MMIO_TIMEOUT - 1) begin
          if (mmio_we_q == 4'b0000) begin
            mmio_dout_d  = MMIO_TIMEOUT_RDATA;
            dout1_mmio_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      mmio_we_q    <= '0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
      mmio_dout_q  <= '0;
      dout1_mmio_q <= 1'b0;
`ifdef RIP_MMIO_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      mmio_we_q    <= mmio_we_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_dout_q  <= mmio_dout_d;
      dout1_mmio_q <= dout1_mmio_d;
`ifdef RIP_MMIO_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign dout_1          = dout1_mmio_q ? mmio_dout_q : ram_dout_a;
  assign busy            = busy_q;
  assign mmio.mmio_req   = busy_q;
  assign mmio.mmio_we    = mmio_we_q;
  assign mmio.mmio_addr  = mmio_addr_q;
  assign mmio.mmio_wdata = mmio_wdata_q;

endmodule
